cache_way_ram: RTL and testbench
================================

CACHE_WAY_RAM -- requirements
Module: cache_way_ram

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways (1, 2, 4 or 8).
REQ-002 SHALL have parameter SETS_LOG2, default 8, log2 of set count.
REQ-003 SHALL have parameter LINE_BITS, default 128, data bits per line.
REQ-004 SHALL derive TAG_BITS = 28 - SETS_LOG2 and WAY_BITS = max(1, clog2(WAYS)); these are not overridable.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- address  in  32  byte address: set = address[SETS_LOG2+3:4], tag = address[31:SETS_LOG2+4].
- read_do  in  1  lookup request.
- write_do  in  1  line fill request.
- write_way  in  WAY_BITS  way to fill.
- data  in  LINE_BITS  fill data.
- inval_do  in  1  invalidate-all request.
- busy  out  1  invalidate sweep in progress.
- hit  out  1  lookup hit.
- hit_way  out  WAY_BITS  way that hit.
- q  out  LINE_BITS  hit-way data; the way-0 line when there is no hit.
- victim_way  out  WAY_BITS  replacement choice for the looked-up set.

Function
REQ-006 Per way, SHALL store {valid, tag, line} per set in a synchronous RAM with a one-cycle read.
REQ-007 read_do in cycle N SHALL present hit, hit_way, q and victim_way for that address in cycle N+1.
REQ-008 Without read_do, outputs SHALL hold the result for the last looked-up set and tag (stored last_set/last_tag; the RAM is re-read at last_set).
REQ-009 hit SHALL be 1 iff exactly one way has valid=1 and a tag equal to the looked-up tag; hit_way SHALL be the lowest matching way.
REQ-010 victim_way SHALL be the lowest invalid way, else the set's round-robin pointer (flop array, WAY_BITS x 2^SETS_LOG2).
REQ-011 write_do SHALL write {1, tag, data} into way write_way at the set; if write_way equals the set's pointer, the pointer SHALL advance modulo WAYS (wrap WAYS-1 -> 0).
REQ-012 A read and a write in the same cycle to the same set SHALL return pre-write contents (unless REQ-020 applies); the write always commits.
REQ-013 FSM states IDLE and SWEEP: inval_do in IDLE -> SWEEP; the set counter starts at 0, clears valid in all ways at one set per cycle, and at 2^SETS_LOG2-1 returns to IDLE on the next cycle.
REQ-014 busy SHALL be 1 exactly while in SWEEP.
REQ-015 During busy, read_do, write_do and inval_do SHALL be ignored, and hit SHALL read 0 for the whole sweep and the first cycle after it.
REQ-016 inval_do together with read_do/write_do in IDLE: inval_do wins and the others are dropped.
REQ-017 WAYS=1: victim_way and hit_way SHALL be constant 0; the pointer array is omitted.

Reset
REQ-018 rst SHALL enter SWEEP at set 0 (busy=1 the cycle after rst), clear all round-robin pointers to 0, and set hit=0, hit_way=0, victim_way=0, last_set=0, last_tag=0.
REQ-019 rst asserted mid-sweep SHALL restart the sweep at set 0.

Configuration
REQ-020 With CACHE_WAY_RAM_BYPASS_EN defined, a same-cycle read and write to the same set SHALL, in cycle N+1, reflect the write: hit and q come from the written way, matched against the new tag. Undefined: REQ-012 behaviour with no forwarding logic.

Structure
REQ-021 A shared package (cache_pkg) SHALL hold the address field offsets (line offset 4, address width 32) and the FSM state encodings.
REQ-022 SHALL instantiate the existing simple_ram once per way (width 1+TAG_BITS+LINE_BITS, widthad SETS_LOG2) via a generate loop; no new sub-module.

Verification (WAYS=2, SETS_LOG2=8, LINE_BITS=128)
REQ-023 Reset: rst for 1 cycle -> busy high for 256 cycles, then 0; read 0x0000_1230 -> hit=0, victim_way=0.
REQ-024 Fill and hit: write 0x0000_1230 way0 data=0xA5..A5, then read 0x0000_1230 -> hit=1, hit_way=0, q=0xA5..A5; read 0x0000_2230 -> hit=0, victim_way=1.
REQ-025 Round-robin: fill set 0x23 in way0 and way1 (pointer advances 0 -> 1 on the way0 fill, 1 -> 0 wrap on the way1 fill), then read a new tag in set 0x23 -> victim_way=0.
REQ-026 Invalidate: after fills, pulse inval_do together with write_do -> write dropped, busy=1 for 256 cycles, and every prior address then reads hit=0.
REQ-027 Same-set read and write at 0x0000_5670, way1, data=0x11..11: without the macro, hit=0; with CACHE_WAY_RAM_BYPASS_EN, hit=1, hit_way=1, q=0x11..11.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: values shared by the cache way RAM files.
//   ADDR_W        byte address width
//   LINE_OFS      bit position of the set index (16-byte lines)
//   sweep_state_t invalidate sweep FSM encoding
package cache_pkg;

   localparam int ADDR_W   = 32;
   localparam int LINE_OFS = 4;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

endpackage

// File: rtl/simple_ram.sv
// simple_ram: single-clock RAM with one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address, sampled on the clock edge
//   q      read data, valid the cycle after raddr is sampled
module simple_ram #(
   parameter int width   = 8,
   parameter int widthad = 4
) (
   input  logic               clk,
   input  logic               we,
   input  logic [widthad-1:0] waddr,
   input  logic [width-1:0]   wdata,
   input  logic [widthad-1:0] raddr,
   output logic [width-1:0]   q
);

   logic [width-1:0] mem [2**widthad];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
   end

endmodule

// File: rtl/cache_way_ram.sv
// cache_way_ram: tag/data store for a set-associative cache. Each way holds
// {valid, tag, line} per set in a simple_ram; lookups answer one cycle after
// read_do, fills pick their way explicitly, and inval_do sweeps every set
// clearing valid (one set per cycle) while busy is high.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (starts a sweep)
//   address       byte address: set = [SETS_LOG2+3:4], tag = [31:SETS_LOG2+4]
//   read_do       lookup request
//   write_do      line fill into way write_way with data
//   inval_do      invalidate-all request
//   busy          sweep in progress
//   hit, hit_way  single-way tag match and the lowest matching way
//   q             hit-way line, or the way-0 line when there is no hit
//   victim_way    lowest invalid way, else the set's round-robin pointer
//
// Build option: CACHE_WAY_RAM_BYPASS_EN forwards a same-cycle fill into the
// lookup result; without it the lookup sees pre-fill contents.
//
// state    | meaning
// ST_IDLE  | accepting lookups, fills and invalidate requests
// ST_SWEEP | clearing valid at sweep_set; all requests ignored
module cache_way_ram
   import cache_pkg::*;
#(
   parameter int WAYS      = 2,
   parameter int SETS_LOG2 = 8,
   parameter int LINE_BITS = 128
) (
   input  logic                                              clk,
   input  logic                                              rst,
   input  logic [ADDR_W-1:0]                                 address,
   input  logic                                              read_do,
   input  logic                                              write_do,
   input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]        write_way,
   input  logic [LINE_BITS-1:0]                              data,
   input  logic                                              inval_do,
   output logic                                              busy,
   output logic                                              hit,
   output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]        hit_way,
   output logic [LINE_BITS-1:0]                              q,
   output logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0]        victim_way
);

   localparam int TAG_BITS = ADDR_W - LINE_OFS - SETS_LOG2;
   localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int ENT_W    = 1 + TAG_BITS + LINE_BITS;
   localparam int NSETS    = 1 << SETS_LOG2;

   logic [SETS_LOG2-1:0] addr_set;
   logic [TAG_BITS-1:0]  addr_tag;
   logic                 unused_lsb;

   assign addr_set   = address[SETS_LOG2+LINE_OFS-1:LINE_OFS];
   assign addr_tag   = address[ADDR_W-1:SETS_LOG2+LINE_OFS];
   assign unused_lsb = ^address[LINE_OFS-1:0];

   sweep_state_t         state, state_nxt;
   logic [SETS_LOG2-1:0] sweep_set, sweep_set_nxt;
   logic                 busy_d;
   logic                 idle;
   logic                 rd_acc, wr_acc;

   assign busy   = (state == ST_SWEEP);
   assign idle   = (state == ST_IDLE);
   // inval_do takes priority over a lookup or fill presented with it
   assign rd_acc = idle && read_do  && !inval_do;
   assign wr_acc = idle && write_do && !inval_do;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_SWEEP;
         sweep_set <= '0;
      end else begin
         state     <= state_nxt;
         sweep_set <= sweep_set_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sweep_set_nxt = sweep_set;
      case (state)
         ST_IDLE: begin
            if (inval_do) begin
               state_nxt     = ST_SWEEP;
               sweep_set_nxt = '0;
            end
         end
         ST_SWEEP: begin
            if (sweep_set == {SETS_LOG2{1'b1}}) state_nxt = ST_IDLE;
            else sweep_set_nxt = sweep_set + 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   logic [SETS_LOG2-1:0] last_set;
   logic [TAG_BITS-1:0]  last_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_set <= '0;
         last_tag <= '0;
         busy_d   <= 1'b1;
      end else begin
         busy_d <= busy;
         if (rd_acc) begin
            last_set <= addr_set;
            last_tag <= addr_tag;
         end
      end
   end

   // With no lookup the RAM keeps re-reading last_set so the result tracks
   // any fill to that set.
   logic [SETS_LOG2-1:0] ram_raddr;
   logic [SETS_LOG2-1:0] ram_waddr;
   logic [ENT_W-1:0]     ram_wdata;
   logic [ENT_W-1:0]     ram_q [WAYS];
   logic [ENT_W-1:0]     ent   [WAYS];

   assign ram_raddr = rd_acc ? addr_set : last_set;
   assign ram_waddr = busy ? sweep_set : addr_set;
   assign ram_wdata = busy ? '0 : {1'b1, addr_tag, data};

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic way_we;
      assign way_we = busy || (wr_acc && (write_way == WAY_BITS'(w)));

      simple_ram #(
         .width   (ENT_W),
         .widthad (SETS_LOG2)
      ) u_ram (
         .clk   (clk),
         .we    (way_we),
         .waddr (ram_waddr),
         .wdata (ram_wdata),
         .raddr (ram_raddr),
         .q     (ram_q[w])
      );
   end

`ifdef CACHE_WAY_RAM_BYPASS_EN
   // A fill paired with a lookup shares the address, so the forwarded entry
   // always carries last_tag.
   logic                 fwd_vld;
   logic [WAY_BITS-1:0]  fwd_way;
   logic [LINE_BITS-1:0] fwd_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_vld <= 1'b0;
      end else begin
         fwd_vld  <= rd_acc && wr_acc;
         fwd_way  <= write_way;
         fwd_line <= data;
      end
   end

   always_comb begin
      for (int w = 0; w < WAYS; w++) begin
         ent[w] = ram_q[w];
         if (fwd_vld && (fwd_way == WAY_BITS'(w))) ent[w] = {1'b1, last_tag, fwd_line};
      end
   end
`else
   always_comb begin
      for (int w = 0; w < WAYS; w++) ent[w] = ram_q[w];
   end
`endif

   logic [WAYS-1:0]     match;
   logic [WAYS-1:0]     empty;
   logic [WAY_BITS-1:0] low_match;
   logic [WAY_BITS-1:0] low_empty;
   logic                hit_raw;

   always_comb begin
      match     = '0;
      empty     = '0;
      low_match = '0;
      low_empty = '0;
      for (int w = 0; w < WAYS; w++) begin
         match[w] = ent[w][ENT_W-1] && (ent[w][LINE_BITS +: TAG_BITS] == last_tag);
         empty[w] = !ent[w][ENT_W-1];
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (match[w]) low_match = WAY_BITS'(w);
         if (empty[w]) low_empty = WAY_BITS'(w);
      end
   end

   // Duplicate tags across ways are a miss. The cycle after a sweep is also
   // masked: its RAM read may predate the clear of the last set.
   assign hit_raw = ($countones(match) == 1);
   assign hit     = hit_raw && !busy && !busy_d;

   always_comb begin
      q = ent[0][LINE_BITS-1:0];
      for (int w = 1; w < WAYS; w++) begin
         if (hit && (low_match == WAY_BITS'(w))) q = ent[w][LINE_BITS-1:0];
      end
   end

   if (WAYS > 1) begin : g_rr
      logic [WAY_BITS-1:0] rr_ptr [NSETS];

      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < NSETS; s++) rr_ptr[s] <= '0;
         end else if (wr_acc && (write_way == rr_ptr[addr_set])) begin
            rr_ptr[addr_set] <= (rr_ptr[addr_set] == WAY_BITS'(WAYS - 1)) ?
                                '0 : rr_ptr[addr_set] + 1'b1;
         end
      end

      assign hit_way    = busy ? '0 : low_match;
      assign victim_way = busy ? '0 : ((|empty) ? low_empty : rr_ptr[last_set]);
   end else begin : g_one
      assign hit_way    = '0;
      assign victim_way = '0;
   end

endmodule

// File: tb/tb_cache_way_ram.sv
module tb_cache_way_ram;

   localparam int WAYS      = 2;
   localparam int SETS_LOG2 = 8;
   localparam int LINE_BITS = 128;
   localparam int NSETS     = 256;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  address = '0;
   logic         read_do = 1'b0;
   logic         write_do = 1'b0;
   logic [0:0]   write_way = '0;
   logic [127:0] data = '0;
   logic         inval_do = 1'b0;
   logic         busy;
   logic         hit;
   logic [0:0]   hit_way;
   logic [127:0] q;
   logic [0:0]   victim_way;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cache_way_ram #(
      .WAYS      (WAYS),
      .SETS_LOG2 (SETS_LOG2),
      .LINE_BITS (LINE_BITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .read_do    (read_do),
      .write_do   (write_do),
      .write_way  (write_way),
      .data       (data),
      .inval_do   (inval_do),
      .busy       (busy),
      .hit        (hit),
      .hit_way    (hit_way),
      .q          (q),
      .victim_way (victim_way)
   );

   // reference model: contents of each way per set plus round-robin pointers
   logic         m_valid [2][NSETS];
   logic [19:0]  m_tag   [2][NSETS];
   logic [127:0] m_data  [2][NSETS];
   logic         m_ptr   [NSETS];
   logic [31:0]  written [$];

   typedef struct packed {
      logic         hit;
      logic         way;
      logic         vic;
      logic         qk;
      logic [127:0] q;
   } res_t;

   function automatic void model_reset();
      for (int s = 0; s < NSETS; s++) begin
         m_ptr[s] = 1'b0;
         for (int w = 0; w < 2; w++) m_valid[w][s] = 1'b0;
      end
   endfunction

   function automatic void model_inval();
      for (int s = 0; s < NSETS; s++)
         for (int w = 0; w < 2; w++) m_valid[w][s] = 1'b0;
   endfunction

   function automatic void model_write(input logic [31:0] a, input int w, input logic [127:0] d);
      int s = int'(a[11:4]);
      m_valid[w][s] = 1'b1;
      m_tag[w][s]   = a[31:12];
      m_data[w][s]  = d;
      if (w == int'(m_ptr[s])) m_ptr[s] = (w + 1) % WAYS != 0;
      written.push_back(a);
   endfunction

   function automatic res_t model_lookup(input logic [31:0] a);
      res_t r;
      int   s = int'(a[11:4]);
      int   n = 0;
      int   low = -1;
      int   inv = -1;
      r = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (m_valid[w][s] && m_tag[w][s] == a[31:12]) begin
            n++;
            if (low < 0) low = w;
         end
         if (!m_valid[w][s] && inv < 0) inv = w;
      end
      r.hit = (n == 1);
      r.way = (low > 0);
      r.vic = (inv >= 0) ? (inv > 0) : m_ptr[s];
      r.q   = r.hit ? m_data[low][s] : m_data[0][s];
      r.qk  = r.hit || m_valid[0][s];
      return r;
   endfunction

   // one clock cycle of stimulus; returns 1 time unit after the edge
   task automatic drive(input logic rd, input logic wr, input logic inv, input logic w,
                        input logic [31:0] a, input logic [127:0] d);
      @(negedge clk);
      read_do   = rd;
      write_do  = wr;
      inval_do  = inv;
      write_way = w;
      address   = a;
      data      = d;
      @(posedge clk);
      #1;
      read_do  = 1'b0;
      write_do = 1'b0;
      inval_do = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, address, data);
   endtask

   task automatic test_reset();
      int n;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
      n_checks++;
      if (victim_way !== 1'b0 || hit_way !== 1'b0) begin
         n_fail++; $display("FAIL reset_ways victim=%b hit_way=%b want 0", victim_way, hit_way);
      end
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         n_checks++;
         if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_sweep_hit cycle %0d got %b want 0", n, hit); end
         idle();
         n++;
      end
      n_checks++;
      if (n != NSETS) begin n_fail++; $display("FAIL reset_busy_len got %0d want %0d", n, NSETS); end
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_post_hit got %b want 0", hit); end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1230, '0);
      n_checks++;
      if (hit !== 1'b0 || victim_way !== 1'b0) begin
         n_fail++; $display("FAIL reset_read hit=%b victim=%b want 0/0", hit, victim_way);
      end
   endtask

   task automatic test_fill_hit();
      res_t e;
      logic [127:0] d = {16{8'hA5}};
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1230, d);
      model_write(32'h0000_1230, 0, d);
      e = model_lookup(32'h0000_1230);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1230, '0);
      n_checks++;
      if (hit !== e.hit || hit_way !== e.way || q !== e.q) begin
         n_fail++; $display("FAIL fill_hit hit=%b way=%b q=%h want %b/%b/%h", hit, hit_way, q, e.hit, e.way, e.q);
      end
      e = model_lookup(32'h0000_2230);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_2230, '0);
      n_checks++;
      if (hit !== e.hit || victim_way !== e.vic) begin
         n_fail++; $display("FAIL fill_miss hit=%b victim=%b want %b/%b", hit, victim_way, e.hit, e.vic);
      end
   endtask

   task automatic test_round_robin();
      res_t e;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3230, 128'h3);
      model_write(32'h0000_3230, 0, 128'h3);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4230, 128'h4);
      model_write(32'h0000_4230, 1, 128'h4);
      e = model_lookup(32'h0000_5230);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5230, '0);
      n_checks++;
      if (hit !== e.hit || victim_way !== e.vic) begin
         n_fail++; $display("FAIL rr_victim hit=%b victim=%b want %b/%b", hit, victim_way, e.hit, e.vic);
      end
      e = model_lookup(32'h0000_4230);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_4230, '0);
      n_checks++;
      if (hit !== e.hit || hit_way !== e.way || q !== e.q) begin
         n_fail++; $display("FAIL rr_hit_way1 hit=%b way=%b q=%h want %b/%b/%h", hit, hit_way, q, e.hit, e.way, e.q);
      end
   endtask

   task automatic test_same_set();
      res_t e;
      logic [127:0] d = {16{8'h11}};
      e = model_lookup(32'h0000_5670);
`ifdef CACHE_WAY_RAM_BYPASS_EN
      e.hit = 1'b1;
      e.way = 1'b1;
      e.q   = d;
      e.qk  = 1'b1;
`endif
      drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_5670, d);
      model_write(32'h0000_5670, 1, d);
      n_checks++;
      if (hit !== e.hit || (e.hit && (hit_way !== e.way || q !== e.q))) begin
         n_fail++; $display("FAIL same_set hit=%b way=%b q=%h want %b/%b/%h", hit, hit_way, q, e.hit, e.way, e.q);
      end
      e = model_lookup(32'h0000_5670);
      idle();
      n_checks++;
      if (hit !== e.hit || hit_way !== e.way || q !== e.q) begin
         n_fail++; $display("FAIL same_set_after hit=%b way=%b q=%h want %b/%b/%h", hit, hit_way, q, e.hit, e.way, e.q);
      end
   endtask

   task automatic test_random();
      res_t e;
      logic [31:0] a;
      logic [127:0] d;
      logic w;
      for (int i = 0; i < 300; i++) begin
         a = {20'($urandom_range(1, 3)), 8'h40 + 8'($urandom_range(0, 3)), 4'($urandom)};
         if ($urandom_range(0, 1) == 0) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            w = 1'($urandom);
            drive(1'b0, 1'b1, 1'b0, w, a, d);
            model_write(a, int'(w), d);
         end else begin
            e = model_lookup(a);
            drive(1'b1, 1'b0, 1'b0, 1'b0, a, '0);
            n_checks++;
            if (hit !== e.hit || hit_way !== e.way || victim_way !== e.vic || (e.qk && q !== e.q)) begin
               n_fail++;
               $display("FAIL random_read %0d addr=%h hit=%b way=%b vic=%b q=%h want %b/%b/%b/%h",
                        i, a, hit, hit_way, victim_way, q, e.hit, e.way, e.vic, e.q);
            end
         end
      end
   endtask

   task automatic test_hold();
      res_t e;
      logic [31:0] a = 32'h0000_9440;
      e = model_lookup(a);
      drive(1'b1, 1'b0, 1'b0, 1'b0, a, '0);
      for (int i = 0; i < 3; i++) begin
         idle();
         n_checks++;
         if (hit !== e.hit || hit_way !== e.way || victim_way !== e.vic) begin
            n_fail++; $display("FAIL hold_%0d hit=%b way=%b vic=%b want %b/%b/%b", i, hit, hit_way, victim_way, e.hit, e.way, e.vic);
         end
      end
      drive(1'b0, 1'b1, 1'b0, 1'b1, a, 128'hBEEF);
      model_write(a, 1, 128'hBEEF);
      idle();
      e = model_lookup(a);
      n_checks++;
      if (hit !== e.hit || hit_way !== e.way || victim_way !== e.vic || (e.qk && q !== e.q)) begin
         n_fail++; $display("FAIL hold_refresh hit=%b way=%b vic=%b q=%h want %b/%b/%b/%h",
                            hit, hit_way, victim_way, q, e.hit, e.way, e.vic, e.q);
      end
   endtask

   task automatic test_inval_with_write();
      res_t e;
      int n;
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_7770, 128'h77);
      model_inval();
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         idle();
         n++;
      end
      n_checks++;
      if (n != NSETS) begin n_fail++; $display("FAIL inval_busy_len got %0d want %0d", n, NSETS); end
      n_checks++;
      if (hit !== 1'b0) begin n_fail++; $display("FAIL inval_post_hit got %b want 0", hit); end
      e = model_lookup(32'h0000_7770);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7770, '0);
      n_checks++;
      if (hit !== e.hit) begin n_fail++; $display("FAIL inval_dropped_write hit=%b want %b", hit, e.hit); end
      for (int i = 0; i < written.size(); i++) begin
         e = model_lookup(written[i]);
         drive(1'b1, 1'b0, 1'b0, 1'b0, written[i], '0);
         n_checks++;
         if (hit !== e.hit || victim_way !== e.vic) begin
            n_fail++; $display("FAIL inval_prior addr=%h hit=%b vic=%b want %b/%b", written[i], hit, victim_way, e.hit, e.vic);
         end
      end
   endtask

   task automatic test_busy_ignores();
      res_t e;
      int n;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, '0);
      model_inval();
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         if (n == 20) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0009_0000, 128'h99);
         else idle();
         n++;
      end
      n_checks++;
      if (n != NSETS) begin n_fail++; $display("FAIL busy_ignore_len got %0d want %0d", n, NSETS); end
      e = model_lookup(32'h0009_0000);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0009_0000, '0);
      n_checks++;
      if (hit !== e.hit || victim_way !== e.vic) begin
         n_fail++; $display("FAIL busy_ignore_write hit=%b vic=%b want %b/%b", hit, victim_way, e.hit, e.vic);
      end
   endtask

   task automatic test_reset_mid_sweep();
      int n;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, '0);
      for (int i = 0; i < 100; i++) idle();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      n = 0;
      while (busy === 1'b1 && n < 400) begin
         idle();
         n++;
      end
      n_checks++;
      if (n != NSETS) begin n_fail++; $display("FAIL mid_sweep_reset_len got %0d want %0d", n, NSETS); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fill_hit();
      test_round_robin();
      test_same_set();
      test_random();
      test_hold();
      test_inval_with_write();
      test_busy_ignores();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
